// File: rtl/dot_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_pipe_if
// Purpose  : Bundles the stream-in / stream-out signals of the dot-product
//            engine: upstream FIFO read port (in_*) and the output FIFO
//            first-word-fall-through read port (out*), plus the overflow flag.
// Ports    : in_x, in_y      N packed signed lanes, lane i at [i*WIDTH +: WIDTH]
//            in_mode         0: x.y, 1: x.x (in_y ignored)
//            in_empty        upstream FIFO empty
//            in_rd_en        pop upstream (data sampled at this edge)
//            out             head of output FIFO
//            out_empty       output FIFO empty
//            out_rd_en       consumer pop
//            out_count       entries held in output FIFO
//            ovf_sticky      sticky overflow indicator
// Modports : slave  - the engine
//            master - the surrounding environment (producer + consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface dot_pipe_if #(
  parameter int WIDTH      = 32,
  parameter int N          = 3,
  parameter int FIFO_DEPTH = 16
);
  logic [N*WIDTH-1:0]              in_x;
  logic [N*WIDTH-1:0]              in_y;
  logic                            in_mode;
  logic                            in_empty;
  logic                            in_rd_en;
  logic [WIDTH-1:0]                out;
  logic                            out_empty;
  logic                            out_rd_en;
  logic [$clog2(FIFO_DEPTH+1)-1:0] out_count;
  logic                            ovf_sticky;

  modport slave (
    input  in_x, in_y, in_mode, in_empty, out_rd_en,
    output in_rd_en, out, out_empty, out_count, ovf_sticky
  );

  modport master (
    output in_x, in_y, in_mode, in_empty, out_rd_en,
    input  in_rd_en, out, out_empty, out_count, ovf_sticky
  );
endinterface
`default_nettype wire

// File: rtl/dot_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dot_pipe
// Purpose  : Fully pipelined signed fixed-point dot product (x.y or x.x) with
//            per-product arithmetic right shift by Q_BITS, optional saturation,
//            sticky overflow flag and an integrated FWFT output FIFO.
//            Pop-to-visible latency is 3 clock edges; throughput 1 per cycle.
// Ports    : clock  rising-edge clock
//            reset  asynchronous, active-low
//            bus    dot_pipe_if.slave (input stream, output FIFO, ovf flag)
// Revision : 1.0 - initial release
// ============================================================================
module dot_pipe #(
  parameter int WIDTH      = 32,
  parameter int N          = 3,
  parameter int Q_BITS     = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int SATURATE   = 1
) (
  input  wire logic   clock,
  input  wire logic   reset,
  dot_pipe_if.slave   bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + $clog2(N) + 1;

  // Pipeline state
  logic                 v1, v2;
  logic signed [PW-1:0] prod   [N];
  logic signed [PW-1:0] prod_q [N];
  logic [WIDTH-1:0]     res_d, res_q;
  logic                 ovf_d, ovf_q;

  // Output FIFO state
  logic [WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     last_q;
  logic                 do_rd;

  // Credit: FIFO occupancy plus results still in the pipe
  logic [CW:0]          used;
  logic                 accept;

  assign used   = {1'b0, count} + {{CW{1'b0}}, v1} + {{CW{1'b0}}, v2};
  assign accept = reset & ~bus.in_empty & (used < (CW+1)'(FIFO_DEPTH));
  assign do_rd  = bus.out_rd_en & (count != '0);

  // S1: full-precision lane products; operands sign-extended so the
  // low 2*WIDTH bits of the product are exact.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_lane
    logic [WIDTH-1:0] xl, yl;
    assign xl       = bus.in_x[gi*WIDTH +: WIDTH];
    assign yl       = bus.in_mode ? xl : bus.in_y[gi*WIDTH +: WIDTH];
    assign prod[gi] = $signed({{WIDTH{xl[WIDTH-1]}}, xl})
                    * $signed({{WIDTH{yl[WIDTH-1]}}, yl});
  end

  // S2: shift each product (floor), accumulate wide enough never to wrap,
  // then range-check against the WIDTH signed range.
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] ext;
  logic [SW-WIDTH:0]    hi;

  always_comb begin
    sum = '0;
    ext = '0;
    for (int i = 0; i < N; i++) begin
      ext = {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};
      sum = sum + (ext >>> Q_BITS);
    end
    // In range only when every bit above the result sign bit matches it
    hi    = sum[SW-1:WIDTH-1];
    ovf_d = ~((&hi) | ~(|hi));
    res_d = sum[WIDTH-1:0];
    if (ovf_d && (SATURATE != 0)) begin
      res_d = sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Datapath registers: no reset needed, qualified by the valid bits
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      prod_q[i] <= prod[i];
    end
    res_q <= res_d;
    if (v2) begin
      mem[wr_ptr] <= res_q;
    end
  end

  // Control: valids, FIFO pointers/count, sticky flag, last popped value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      last_q <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (v1 && ovf_d) begin
        ovf_q <= 1'b1;
      end
      if (v2) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        // Keeps the output stable once the FIFO runs empty
        last_q <= mem[rd_ptr];
      end
      count <= count + CW'(v2) - CW'(do_rd);
    end
  end

  assign bus.in_rd_en   = accept;
  assign bus.out        = (count != '0) ? mem[rd_ptr] : last_q;
  assign bus.out_empty  = (count == '0);
  assign bus.out_count  = count;
  assign bus.ovf_sticky = ovf_q;

endmodule
`default_nettype wire
